// File: rtl/dcache_write_arbiter.sv
// N-way data-array write arbiter: fixed/round-robin grant, burst lock, registered output.
// One cycle from input handshake to output; a held output (valid & ~ready) deasserts every input ready.
module dcache_write_arbiter #(
  parameter int N_IN    = 8,
  parameter int WAY_W   = 8,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128,
  parameter int RR_MODE = 1,
  parameter int BEATS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_IN-1:0]          io_in_valid,
  output logic [N_IN-1:0]          io_in_ready,
  input  logic [N_IN*WAY_W-1:0]    io_in_bits_way_en,
  input  logic [N_IN*ADDR_W-1:0]   io_in_bits_addr,
  input  logic [N_IN*DATA_W-1:0]   io_in_bits_data,
  input  logic                     io_out_ready,
  output logic                     io_out_valid,
  output logic [WAY_W-1:0]         io_out_bits_way_en,
  output logic [ADDR_W-1:0]        io_out_bits_addr,
  output logic [DATA_W-1:0]        io_out_bits_data,
  output logic [$clog2(N_IN)-1:0]  io_out_chosen
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [WAY_W-1:0]  way_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_beat_t;

  logic             out_free;
  logic             in_hs;
  logic             grant_vld;
  logic [N_IN-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             locked;
  logic [IDX_W-1:0] lock_ch;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  wr_beat_t         sel_beat;
  wr_beat_t         out_beat;

  // Descending scans so the last hit is the lowest index / nearest to rr_ptr.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (locked) begin
      if (io_in_valid[lock_ch]) begin
        grant_vld = 1'b1;
        grant_idx = lock_ch;
      end
    end else if (RR_MODE == 0) begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (io_in_valid[IDX_W'(i)]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end else begin
      for (int k = N_IN - 1; k >= 0; k--) begin
        j = int'(rr_ptr) + k;
        if (j >= N_IN) j = j - N_IN;
        if (io_in_valid[IDX_W'(j)]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_beat.way_en = io_in_bits_way_en[int'(grant_idx)*WAY_W +: WAY_W];
    sel_beat.addr   = io_in_bits_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_beat.data   = io_in_bits_data[int'(grant_idx)*DATA_W +: DATA_W];
  end

  assign out_free    = ~io_out_valid | io_out_ready;
  assign in_hs       = grant_vld & out_free;
  assign io_in_ready = grant & {N_IN{out_free}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_beat      <= '0;
      io_out_valid  <= 1'b0;
      io_out_chosen <= '0;
    end else if (in_hs) begin
      out_beat      <= sel_beat;
      io_out_valid  <= 1'b1;
      io_out_chosen <= grant_idx;
    end else if (io_out_ready) begin
      io_out_valid  <= 1'b0;
    end
  end

  assign io_out_bits_way_en = out_beat.way_en;
  assign io_out_bits_addr   = out_beat.addr;
  assign io_out_bits_data   = out_beat.data;

  // The pointer advances only at burst end so a locked burst never skews fairness.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      locked   <= 1'b0;
      lock_ch  <= '0;
      rr_ptr   <= '0;
    end else if (in_hs) begin
      if (beat_cnt == CNT_W'(BEATS - 1)) begin
        beat_cnt <= '0;
        locked   <= 1'b0;
        if (RR_MODE != 0)
          rr_ptr <= (grant_idx == IDX_W'(N_IN - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        locked   <= 1'b1;
        lock_ch  <= grant_idx;
      end
    end
  end

endmodule

// File: doc/dcache_write_arbiter.md
# dcache_write_arbiter

Parametrised N-way arbiter for data-array write requests (way enable, address, data) feeding the dcache data array. It is the next generation of the fixed 8-input priority write arbiter: it adds selectable round-robin fairness, multi-beat burst locking so that one requester's beats are never interleaved, and a registered output stage that breaks the path from requester to SRAM. It sits between the dcache write sources (refill, store pipeline, MSHR replay) and the data-array write port.

## Interface
- N_IN, 8, number of requesting channels (≥2)
- WAY_W, 8, width of the way-enable field
- ADDR_W, 12, width of the address field
- DATA_W, 128, width of the data field
- RR_MODE, 1, 0 = fixed priority (channel 0 highest); 1 = round-robin
- BEATS, 1, beats per grant; the grant stays locked to one channel until BEATS handshakes complete (≥1)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- io_in_valid  in  N_IN  per-channel request valid
- io_in_ready  out  N_IN  per-channel accept
- io_in_bits_way_en  in  N_IN*WAY_W  channel i at [i*WAY_W +: WAY_W]
- io_in_bits_addr  in  N_IN*ADDR_W  packed the same way
- io_in_bits_data  in  N_IN*DATA_W  packed the same way
- io_out_ready  in  1  downstream accept
- io_out_valid  out  1  registered output valid
- io_out_bits_way_en / _addr / _data  out  WAY_W / ADDR_W / DATA_W  registered payload
- io_out_chosen  out  clog2(N_IN)  index of the channel that produced the current output

## Operation
- Output register: `out_free = ~io_out_valid | io_out_ready`.
- Grant (combinational, one-hot or zero):
  - While locked: only `lock_ch` is eligible. Other channels see ready=0 even when `lock_ch` is idle.
  - Unlocked, RR_MODE=0: the lowest valid index wins.
  - Unlocked, RR_MODE=1: search starts at `rr_ptr` and wraps modulo N_IN; the first valid channel wins.
- `io_in_ready[i] = grant[i] & out_free`. A handshake on channel i loads that channel's payload into the output register, sets io_out_valid=1 and sets io_out_chosen=i.
- If io_out_ready=1 and no input handshake occurs, io_out_valid clears to 0. Payload registers hold their last value.
- Beat counter `beat_cnt` (width clog2(BEATS), minimum 1 bit):
  - Every accepted input beat increments it.
  - On the first beat of a grant with BEATS>1: `locked` is set and `lock_ch` is set to the granted channel.
  - On the beat where `beat_cnt == BEATS-1`: `beat_cnt` returns to 0 and `locked` clears.
  - With BEATS=1 the block never locks.
- `rr_ptr` updates only when a burst completes, to `(granted+1)` with wrap (index N_IN-1 → 0). In RR_MODE=0, `rr_ptr` is unused and held at 0.
- Reset values (asynchronous): io_out_valid=0, all payload outputs=0, io_out_chosen=0, rr_ptr=0, beat_cnt=0, locked=0, lock_ch=0. Reset during a burst abandons it; after reset the first grant follows the normal unlocked rules.

## Timing
- Latency: an input handshake in cycle t appears on the output in cycle t+1.
- Throughput: 1 beat per cycle while io_out_ready=1.
- Backpressure:
  - With io_out_valid=1 and io_out_ready=0, all io_in_ready=0 and the output is stable (valid/bits/chosen do not change).
  - Simultaneous io_out_ready=1 and an input handshake: the new beat replaces the old one with no bubble.
- io_in_ready depends combinationally on io_out_ready and io_in_valid. io_out_* are driven directly from flops.
- No combinational path from io_in_bits to any output.

## Test plan
- Fixed priority (RR_MODE=0, BEATS=1, io_out_ready=1): channels 2, 5 and 7 all valid → out_chosen sequence is 2,2,2… while 2 stays valid. Drop 2 → the next grant is 5, then 7 after 5 drops. Each payload appears one cycle after its handshake.
- Round-robin (RR_MODE=1, BEATS=1): all 8 channels valid continuously from reset → out_chosen is 0,1,2…7,0, one per cycle. Wrap from 7 to 0 is checked.
- Burst lock (BEATS=4): ch3 and ch1 valid; ch3 is granted first via rr_ptr=3 after a prior ch2 grant → four ch3 beats are output consecutively. Deassert ch3 valid for 2 cycles mid-burst → ch1 ready stays 0 and the burst resumes. After the 4th beat, ch1 is granted.
- Backpressure: io_out_ready=0 with data 0xA5… held in the output → io_out_bits and io_out_chosen are unchanged for 10 cycles and all io_in_ready=0. Raise io_out_ready with ch0 valid → a same-cycle swap, io_out_valid stays 1.
- Reset mid-burst: assert reset after beat 2 of 4 → io_out_valid goes 0 immediately. After release, with ch0 and ch6 valid, the RR grant is ch0 (rr_ptr=0) and ch0 is not locked out by the stale burst.
- Parameter sweep: N_IN=2, 3, 16 and BEATS=1, 2, 5 with random valid/ready → the scoreboard sees per-channel ordered, non-interleaved bursts, no lost or duplicated beats, and in RR mode a starvation bound of N_IN·BEATS granted beats.
